rom_stream_reader: RTL and testbench
====================================

# rom_stream_reader

Streaming read sequencer that sits directly upstream of the `rom` block. It accepts a (base, length) read command, drives `address` into the ROM and absorbs the ROM's one-cycle registered read latency. It returns the words as a valid/ready stream with a last-beat marker. Backpressure is handled by a credit-limited output FIFO, so no ROM word is ever dropped or read twice.

## Interface
- `ADDR_W`, 7, ROM address width (matches `rom.address`)
- `DATA_W`, 8, ROM data width (matches `rom.data`)
- `FIFO_DEPTH`, 4, output FIFO entries; must be ≥ 3 for full throughput; power of two
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  command strobe; sampled only in IDLE
- `base_addr`  in  ADDR_W  first address of command
- `length`  in  ADDR_W+1  word count, 0..2^ADDR_W
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse at command completion
- `rom_addr`  out  ADDR_W  registered; connects to `rom.address`
- `rom_data`  in  DATA_W  from `rom.data`; valid one cycle after `rom_addr`
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready
- `out_data`  out  DATA_W  stream word
- `out_last`  out  1  high on final beat of command

## Operation
- FSM states:
  - IDLE: `start` → RUN; `base_addr` and `length` are latched.
  - RUN: all `length` words issued → DRAIN.
  - DRAIN: last beat handshaken → DONE.
  - DONE: one cycle, `done`=1 → IDLE.
- `start` outside IDLE is ignored. Command inputs are don't-care except in the `start` cycle.
- `length`=0: IDLE → DONE directly, skipping RUN and DRAIN. No beats are produced and no ROM reads are issued. `done` pulses 2 cycles after `start`.
- Issue rule: a read is issued in a cycle when state is RUN, `issued < length`, and `fifo_count + inflight − pop < FIFO_DEPTH`. Here `pop` is the same-cycle `out_valid && out_ready`.
- On issue, `rom_addr` is loaded with `base + issued`, modulo 2^ADDR_W. Example: base 0x7E, length 4 reads 0x7E, 0x7F, 0x00, 0x01.
- `inflight` tracks reads whose data has not yet been captured. `rom_data` is pushed into the FIFO exactly 2 cycles after its issue decision: 1 cycle for the `rom_addr` register, 1 cycle of ROM latency.
- Each FIFO entry carries `{last, data}`. `last` is set on the word with index `length−1`.
- A stream transfer occurs when `out_valid && out_ready`. `out_data` and `out_last` hold stable while `out_valid` is high and `out_ready` is low.
- Simultaneous FIFO push and pop are legal at any occupancy, full included. The credit rule guarantees a push never hits a full FIFO.
- The `rom_addr` register holds its last value when not issuing.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rom_addr`=0, `out_valid`=0, `out_last`=0, `out_data`=0, FIFO and all counters empty.
- Reset asserted mid-command aborts it immediately at the next edge. No `done` is produced, and any ROM data arriving afterwards is discarded.
- Latency: with `start` in cycle T, `busy` is 1 from T+1 and `rom_addr`=base in T+1. The first `out_valid` occurs in T+3 and `out_data` is FIFO-registered.
- Throughput: with `out_ready` held 1, one beat per cycle. The last beat falls in T+2+length.
- `done` pulses in the cycle after the last-beat handshake. `busy` falls in that same cycle, and the next `start` is accepted in the following cycle.
- With `out_ready` stalled low, issue stops once FIFO plus in-flight reaches FIFO_DEPTH, and resumes in the cycle `out_ready` returns.

## Structure
- Package `rom_stream_pkg`: FSM state enum (IDLE, RUN, DRAIN, DONE) and the default `ADDR_W`/`DATA_W` constants.
- Sub-module `sync_fifo` (parameterised width and depth, with count output) holds `{last, data}`. The top level holds the FSM, the issue and credit counters, and the address register.

## Test plan
- Basic: base 0, length 128, `out_ready`=1 → 128 beats matching golden `rom` contents at addresses 0..127. `out_last` only on beat 127, first `out_valid` at T+3, `done` at T+131.
- Wrap: base 0x7E, length 4 → ROM reads 0x7E, 0x7F, 0x00, 0x01 in order, `out_last` on beat 4.
- Backpressure: base 0x10, length 16, `out_ready` random 50% → exactly 16 beats, data 0x10..0x1F in order, no duplicates. FIFO plus in-flight never exceeds 4, and data is stable under stall.
- Zero length and busy start: `length`=0 → `done` at T+2 with no `out_valid`. A second `start` during RUN is ignored, so the beat count equals the first command only.
- Reset mid-command: base 0, length 64, `rst_n` low for 1 cycle after 10 beats → all outputs at reset values next cycle, no `done`. A new command (base 0x20, length 2) then completes correctly.

Source files
------------

// File: rtl/rom_stream_pkg.sv
// Shared types and default widths for the ROM stream reader.
package rom_stream_pkg;

   localparam int unsigned DefAddrW = 7;
   localparam int unsigned DefDataW = 8;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is presented combinationally.
module sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;

   // Storage, pointers and count; push and pop may coincide at any occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + CntW'(push) - CntW'(pop);
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Issues sequential ROM reads for a (base, length) command and streams the words out
// through a credit-limited FIFO so a stalled consumer never causes a lost or repeated read.
module rom_stream_reader
   import rom_stream_pkg::*;
#(
   parameter int unsigned ADDR_W     = DefAddrW,
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam int unsigned FcW  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CntW = FcW + 1;
   localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   len_q, issued_q, issued_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              zero_q, zero_d;
   // Two-stage issue pipeline: stage 1 = address registered, stage 2 = ROM data valid.
   logic              v1_q, v2_q, last1_q, last2_q;
   logic              issue, issue_last;
   logic              pop;
   logic [FcW-1:0]    fifo_count;
   logic [CntW-1:0]   credit_used;

   assign out_valid   = (fifo_count != '0);
   assign pop         = out_valid & out_ready;
   assign credit_used = CntW'(fifo_count) + CntW'(v1_q) + CntW'(v2_q) - CntW'(pop);
   assign rom_addr    = rom_addr_q;

   // Next-state, issue decision and status outputs.
   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      rom_addr_d = rom_addr_q;
      zero_d     = zero_q;
      issue      = 1'b0;
      issue_last = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (length == '0) begin
                  // Zero-length commands wait one extra cycle in DONE so done lands at T+2.
                  state_d = StDone;
                  zero_d  = 1'b1;
               end else begin
                  // First read goes out in the start cycle so rom_addr=base at T+1.
                  issue      = 1'b1;
                  issue_last = (length == LenOne);
                  rom_addr_d = base_addr;
                  issued_d   = LenOne;
                  state_d    = StRun;
               end
            end
         end
         StRun: begin
            busy = 1'b1;
            if ((issued_q < len_q) && (credit_used < CntW'(FIFO_DEPTH))) begin
               issue      = 1'b1;
               issue_last = (issued_q == len_q - LenOne);
               rom_addr_d = base_q + issued_q[ADDR_W-1:0];
               issued_d   = issued_q + LenOne;
            end
            if (issued_d == len_q) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            busy = 1'b1;
            if (pop && out_last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (zero_q) begin
               busy   = 1'b1;
               zero_d = 1'b0;
            end else begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, command latch, address register and read pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         base_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         rom_addr_q <= '0;
         zero_q     <= 1'b0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         last1_q    <= 1'b0;
         last2_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         rom_addr_q <= rom_addr_d;
         zero_q     <= zero_d;
         v1_q       <= issue;
         last1_q    <= issue_last;
         v2_q       <= v1_q;
         last2_q    <= last1_q;
         if (state_q == StIdle && start) begin
            base_q <= base_addr;
            len_q  <= length;
         end
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (v2_q),
      .push_data ({last2_q, rom_data}),
      .pop       (pop),
      .pop_data  ({out_last, out_data}),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_rom_stream_reader.sv
// Randomised bench for rom_stream_reader with a queue-based reference model.
module tb_rom_stream_reader;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [6:0] base_addr;
   logic [7:0] length;
   logic       busy, done;
   logic [6:0] rom_addr;
   logic [7:0] rom_data;
   logic       out_valid, out_ready;
   logic [7:0] out_data;
   logic       out_last;

   rom_stream_reader #(
      .ADDR_W     (7),
      .DATA_W     (8),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   // Golden ROM contents.
   function automatic logic [7:0] rom_word(input logic [6:0] a);
      logic [7:0] x;
      x = {1'b0, a};
      return (x * 8'd29 + 8'h5A) ^ (x >> 2);
   endfunction

   // Registered ROM: data valid one cycle after address.
   always @(posedge clk) rom_data <= rom_word(rom_addr);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   int ready_pct = 100;
   always @(posedge clk) begin
      #1;
      out_ready = ($urandom_range(99) < ready_pct);
   end

   // Model state for the current command.
   bit         cmd_active = 0;
   int         t_start, cur_len, reads, beats;
   logic [6:0] cur_base;
   bit         done_seen;
   int         done_cyc, first_valid_cyc, last_beat_cyc;
   logic [7:0] first_data;
   logic [8:0] exp_q[$];
   logic [6:0] addr_log[$];

   logic       prev_rst = 0, prev_valid = 0, prev_ready = 0, prev_last = 0;
   logic [7:0] prev_data = 0;
   logic [6:0] prev_addr = 0;

   // Compare process: checks every cycle against the model.
   always @(negedge clk) begin
      logic [8:0] e;
      int         exp_a;
      if (rst_n) begin
         if (!cmd_active) begin
            check(!out_valid && !done && !busy, "idle_quiet", {out_valid, done, busy}, 0);
         end else begin
            if (cyc == t_start + 1 && cur_len > 0)
               check(rom_addr == cur_base, "first_addr", rom_addr, cur_base);
            if (cyc > t_start && !done) check(busy == 1'b1, "busy_high", busy, 1);
            if (done) begin
               check(busy == 1'b0, "busy_low_at_done", busy, 0);
               done_seen = 1;
               done_cyc  = cyc;
            end
            if (cyc > t_start && ((cyc == t_start + 1 && cur_len > 0) || rom_addr != prev_addr)) begin
               reads++;
               exp_a = (int'(cur_base) + reads - 1) % 128;
               check(rom_addr == 7'(exp_a), "rom_addr_seq", rom_addr, exp_a);
               check(reads <= cur_len, "read_count", reads, cur_len);
               check(reads - beats <= DEPTH, "credit_limit", reads - beats, DEPTH);
               addr_log.push_back(rom_addr);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check(0, "extra_beat", out_data, 0);
               end else begin
                  e = exp_q.pop_front();
                  check({out_last, out_data} == e, "beat", {out_last, out_data}, e);
                  if (beats == 0) first_data = out_data;
                  if (out_last) last_beat_cyc = cyc;
               end
               beats++;
            end
         end
         if (prev_rst && prev_valid && !prev_ready)
            check(out_valid && out_data == prev_data && out_last == prev_last, "stall_hold",
                  {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
      end
      prev_rst   = rst_n;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_addr  = rom_addr;
   end

   task automatic check_reset_values(input string tag);
      check(busy == 1'b0, {tag, "_busy"}, busy, 0);
      check(done == 1'b0, {tag, "_done"}, done, 0);
      check(rom_addr == 7'h0, {tag, "_rom_addr"}, rom_addr, 0);
      check(out_valid == 1'b0, {tag, "_out_valid"}, out_valid, 0);
      check(out_last == 1'b0, {tag, "_out_last"}, out_last, 0);
      check(out_data == 8'h0, {tag, "_out_data"}, out_data, 0);
   endtask

   // Run one command; poke>=0 re-asserts start during the command, rst_after>=0 resets
   // the block once that many beats have been taken.
   task automatic run_cmd(input logic [6:0] b, input int len, input int pct, input int poke,
                          input int rst_after);
      ready_pct = pct;
      @(posedge clk);
      #1;
      start = 1'b1; base_addr = b; length = 8'(len);
      t_start = cyc; cur_base = b; cur_len = len;
      reads = 0; beats = 0; done_seen = 0;
      done_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1;
      addr_log.delete();
      exp_q.delete();
      for (int i = 0; i < len; i++)
         exp_q.push_back({(i == len - 1), rom_word(7'((int'(b) + i) % 128))});
      cmd_active = 1;
      for (int i = 0; i < len * 12 + 40 && !done_seen; i++) begin
         @(posedge clk);
         #1;
         start = (i == poke);
         if (i == poke) begin
            base_addr = 7'h55;
            length    = 8'd5;
         end
         if (rst_after >= 0 && beats >= rst_after) begin
            rst_n = 1'b0; start = 1'b0;
            cmd_active = 0;
            exp_q.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            check_reset_values("mid_reset");
            check(!done_seen, "no_done_before_reset", done_seen, 0);
            return;
         end
      end
      start = 1'b0;
      check(done_seen, "done_timeout", done_seen, 1);
      cmd_active = 0;
      check(beats == len, "beat_total", beats, len);
      check(reads == len, "read_total", reads, len);
      check(exp_q.size() == 0, "model_drained", exp_q.size(), 0);
      if (len == 0) begin
         check(first_valid_cyc == -1, "zero_len_no_valid", first_valid_cyc, -1);
         check(done_cyc == t_start + 2, "zero_len_done", done_cyc - t_start, 2);
      end else begin
         check(first_valid_cyc == t_start + 3, "first_valid_lat", first_valid_cyc - t_start, 3);
         check(done_cyc == last_beat_cyc + 1, "done_after_last", done_cyc - last_beat_cyc, 1);
         if (pct == 100)
            check(done_cyc == t_start + 3 + len, "done_lat", done_cyc - t_start, 3 + len);
      end
   endtask

   logic [6:0] wrap_exp [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("reset");

      // Basic full-ROM sweep at full throughput.
      run_cmd(7'h00, 128, 100, -1, -1);
      check(done_cyc - t_start == 131, "basic_done_T131", done_cyc - t_start, 131);
      check(first_data == 8'h5A, "basic_first_word", first_data, 8'h5A);
      check(last_beat_cyc - t_start == 130, "basic_last_beat", last_beat_cyc - t_start, 130);

      // Address wrap.
      run_cmd(7'h7E, 4, 100, -1, -1);
      wrap_exp = '{7'h7E, 7'h7F, 7'h00, 7'h01};
      check(addr_log.size() == 4, "wrap_read_count", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         check(addr_log[i] == wrap_exp[i], "wrap_addr", addr_log[i], wrap_exp[i]);
      check(last_beat_cyc - t_start == 6, "wrap_last_beat", last_beat_cyc - t_start, 6);

      // Backpressure.
      run_cmd(7'h10, 16, 50, -1, -1);

      // Zero length, then a start poked during RUN.
      run_cmd(7'h33, 0, 100, -1, -1);
      run_cmd(7'h40, 20, 100, 3, -1);

      // Reset mid-command, then a fresh command.
      run_cmd(7'h00, 64, 100, -1, 10);
      repeat (4) @(posedge clk);
      run_cmd(7'h20, 2, 100, -1, -1);

      // Random commands.
      for (int k = 0; k < 8; k++)
         run_cmd(7'($urandom_range(127)), int'($urandom_range(40, 1)),
                 int'($urandom_range(100, 30)), -1, -1);
      run_cmd(7'($urandom_range(127)), 128, 60, -1, -1);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
